// File: rtl/iir_dac_serializer.sv
// Output stage for the 8-bit IIR filter: sample FIFO, offset-binary conversion,
// and an MSB-first three-wire serializer (sclk/sdata/cs_n) toward the DAC.
module iir_dac_serializer #(
    parameter int DIV        = 2,
    parameter int DEPTH      = 4,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 din,
    input  logic                       din_valid,
    output logic                       sclk,
    output logic                       sdata,
    output logic                       cs_n,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    state_t        state_q, state_d;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          sclk_q, sclk_d;
    logic          sdata_q, sdata_d;
    logic          cs_n_q, cs_n_d;
    logic          busy_q, busy_d;

    logic          pop, push, full;
    logic [7:0]    head, code;

    // A full FIFO can still take a sample when the head leaves on the same edge.
    always_comb begin
        pop        = (state_q == IDLE) && (count_q != '0);
        full       = (count_q == FULL_LVL);
        push       = din_valid && (!full || pop);
        head       = mem[rd_ptr_q];
        code       = OFFSET_BIN ? {~head[7], head[6:0]} : head;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | (din_valid & ~push);
        unique case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sample storage has no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        unique case (state_q)
            IDLE: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
                busy_d  = 1'b0;
                if (pop) begin
                    state_d   = SHIFT;
                    shreg_d   = code;
                    sdata_d   = code[7];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt_q == 3'd7) begin
                        state_d = GAP;
                        sclk_d  = 1'b0;
                        sdata_d = 1'b0;
                        cs_n_d  = 1'b1;
                    end else begin
                        // Data only moves on the falling sclk edge so the DAC sees it stable.
                        sclk_d    = 1'b0;
                        shreg_d   = shreg_q << 1;
                        sdata_d   = shreg_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
        end
    end

    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign cs_n       = cs_n_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_level = count_q;

endmodule
